bcd_operand_entry: RTL

- Parametrised front-panel operand entry for the Basys3 CPU designs: a cursor-addressed array of NUM_DIGITS decimal digits, edited with debounced button pulses.
- On a start pulse, a sequential multiply-by-10 converter turns the digit groups into NUM_OPERANDS binary operands.
- Operands are presented to the CPU with a valid/ready handshake.
- Replaces fixed 4-digit/2-operand entry logic; adds clear, selectable wrap/saturate, edit lock and backpressure.

---
 rtl/bcd_operand_entry.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/bcd_operand_entry.sv
// Front-panel BCD operand entry: cursor-edited digit array, sequential
// multiply-by-10 conversion into binary operands, valid/ready output.
module bcd_operand_entry #(
  parameter int NUM_DIGITS   = 8,
  parameter int NUM_OPERANDS = 2,
  parameter int OUT_WIDTH    = 32,
  parameter bit WRAP         = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                btn_up,
  input  logic                                btn_down,
  input  logic                                btn_left,
  input  logic                                btn_right,
  input  logic                                btn_clr,
  input  logic                                go,
  input  logic                                op_ready,
  output logic [$clog2(NUM_DIGITS)-1:0]       cursor,
  output logic [4*NUM_DIGITS-1:0]             digits,
  output logic [NUM_OPERANDS*OUT_WIDTH-1:0]   operands,
  output logic                                op_valid,
  output logic                                busy
);

  localparam int D  = NUM_DIGITS / NUM_OPERANDS;
  localparam int CW = $clog2(NUM_DIGITS);
  localparam int NW = $clog2(NUM_DIGITS + 1);
  localparam int GW = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
  localparam int PW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_VALID} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cursor_q, cursor_d;
  logic [3:0]             digits_q [NUM_DIGITS];
  logic [3:0]             digits_d [NUM_DIGITS];
  logic [OUT_WIDTH-1:0]   ops_q [NUM_OPERANDS];
  logic [OUT_WIDTH-1:0]   ops_d [NUM_OPERANDS];
  logic [NW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          fpos_q, fpos_d;
  logic [GW-1:0]          fgrp_q, fgrp_d;
  logic [3:0]             dig_q, dig_d;
  logic                   acc_en_q, acc_en_d;
  logic [GW-1:0]          acc_grp_q, acc_grp_d;
  logic [3:0]             cur_dig, new_dig;
  logic [CW-1:0]          fetch_idx;

  assign fetch_idx = CW'(NUM_DIGITS - 1) - cnt_q[CW-1:0];

  // Conversion is a two-stage pipe: fetch a digit into dig_q, then fold it
  // into its operand one cycle later, keeping the digit mux off the mul-add.
  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    digits_d  = digits_q;
    ops_d     = ops_q;
    cnt_d     = cnt_q;
    fpos_d    = fpos_q;
    fgrp_d    = fgrp_q;
    dig_d     = dig_q;
    acc_en_d  = acc_en_q;
    acc_grp_d = acc_grp_q;
    cur_dig   = digits_q[cursor_q];
    new_dig   = cur_dig;
    case (state_q)
      S_IDLE: begin
        if (btn_clr) begin
          for (int i = 0; i < NUM_DIGITS; i++) digits_d[i] = 4'd0;
          cursor_d = '0;
        end else begin
          if (btn_up)
            new_dig = (cur_dig == 4'd9) ? (WRAP ? 4'd0 : 4'd9) : cur_dig + 4'd1;
          else if (btn_down)
            new_dig = (cur_dig == 4'd0) ? (WRAP ? 4'd9 : 4'd0) : cur_dig - 4'd1;
          digits_d[cursor_q] = new_dig;
          if (btn_left)
            cursor_d = (cursor_q == CW'(NUM_DIGITS - 1)) ? '0 : cursor_q + 1'b1;
          else if (btn_right)
            cursor_d = (cursor_q == '0) ? CW'(NUM_DIGITS - 1) : cursor_q - 1'b1;
        end
        if (go) begin
          state_d  = S_CONV;
          for (int j = 0; j < NUM_OPERANDS; j++) ops_d[j] = '0;
          cnt_d    = '0;
          fpos_d   = '0;
          fgrp_d   = '0;
          acc_en_d = 1'b0;
        end
      end
      S_CONV: begin
        if (acc_en_q) begin
          for (int j = 0; j < NUM_OPERANDS; j++)
            if (acc_grp_q == GW'(j))
              ops_d[j] = (ops_q[j] << 3) + (ops_q[j] << 1) + OUT_WIDTH'(dig_q);
        end
        if (cnt_q == NW'(NUM_DIGITS)) begin
          acc_en_d = 1'b0;
          state_d  = S_VALID;
        end else begin
          dig_d     = digits_q[fetch_idx];
          acc_en_d  = 1'b1;
          acc_grp_d = fgrp_q;
          cnt_d     = cnt_q + 1'b1;
          if (fpos_q == PW'(D - 1)) begin
            fpos_d = '0;
            fgrp_d = fgrp_q + 1'b1;
          end else begin
            fpos_d = fpos_q + 1'b1;
          end
        end
      end
      S_VALID: begin
        if (op_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cursor_q  <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) digits_q[i] <= 4'd0;
      for (int j = 0; j < NUM_OPERANDS; j++) ops_q[j] <= '0;
      cnt_q     <= '0;
      fpos_q    <= '0;
      fgrp_q    <= '0;
      dig_q     <= 4'd0;
      acc_en_q  <= 1'b0;
      acc_grp_q <= '0;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      digits_q  <= digits_d;
      ops_q     <= ops_d;
      cnt_q     <= cnt_d;
      fpos_q    <= fpos_d;
      fgrp_q    <= fgrp_d;
      dig_q     <= dig_d;
      acc_en_q  <= acc_en_d;
      acc_grp_q <= acc_grp_d;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    assign digits[4*g +: 4] = digits_q[g];
  end
  for (genvar g = 0; g < NUM_OPERANDS; g++) begin : g_ops
    assign operands[g*OUT_WIDTH +: OUT_WIDTH] = ops_q[g];
  end

  assign cursor   = cursor_q;
  assign op_valid = (state_q == S_VALID);
  assign busy     = (state_q != S_IDLE);

endmodule
